trakball_quad_decoder: RTL and testbench
========================================

// Module: trakball_quad_decoder
// PURPOSE
//  Decodes a physical arcade trackball (two quadrature channels + 2 buttons, via USER_IN)
//  into the 25-bit ps2_mouse packet format the cores already consume.
//  Drop-in alternative source for ps2_mouse in the trackball games: the core's
//  mouse-to-quadrature path regenerates trakdata from these packets.
//  Accumulates signed counts between packets and emits one packet per PERIOD.
// PARAMETERS
//  PERIOD      12000  clk_sys cycles between packet opportunities (1 ms at 12 MHz)
//  FILTER_LEN  4      cycles a synchronised input must hold before it is accepted (1..15)
//  INVERT_X    0      1 = negate X step direction
//  INVERT_Y    0      1 = negate Y step direction
// PORTS
//  clk_sys     in   1   system clock (12 MHz in Centipede)
//  reset_n     in   1   asynchronous active-low reset
//  enable      in   1   0 = freeze: no counting, no packets, accumulators held
//  quad_x      in   2   X channel {B,A}, asynchronous pins
//  quad_y      in   2   Y channel {B,A}, asynchronous pins
//  btn_n       in   2   {right,left} buttons, active low, asynchronous
//  ps2_mouse   out  25  [24] toggle, [23:16] dY, [15:8] dX, [7] Yovf, [6] Xovf,
//                       [5] Ysign, [4] Xsign, [3] 1, [2] 0, [1] right, [0] left
//  err_cnt     out  8   saturating count of illegal quadrature transitions
// BEHAVIOUR
//  Reset: ps2_mouse = 25'h0000008, err_cnt = 0, accumulators 0, period counter 0,
//   filtered inputs and previous-state regs = 2'b00, buttons released.
//  Input path per bit: 2-FF synchroniser, then filter: output takes new value only
//   after FILTER_LEN consecutive equal samples differing from current output.
//   Edge on pin -> filtered change after 2+FILTER_LEN cycles.
//  Quadrature decode on filtered {B,A}, prev->cur, Gray sequence 00->01->11->10->00 = +1,
//   reverse = -1, no change = 0; both bits changed = illegal: step 0, err_cnt+1 (sticks at 255).
//   INVERT_* negates the step.
//  Accumulators: 10-bit signed, saturate at +255 / -256; saturation sets sticky ovf flag
//   for that axis until next packet.
//  Period counter: counts 0..PERIOD-1, wraps; tick at PERIOD-1.
//  Emission on tick when dX!=0 or dY!=0 or buttons differ from last emitted values:
//   ps2_mouse registered next cycle; [24] inverted; [15:8]=dX[7:0], [4]=dX[8];
//   same for Y; ovf flags copied; accumulators/flags cleared.
//   Tick with nothing to report: ps2_mouse unchanged (no toggle).
//  Simultaneous step and emitting tick: accumulator loads the step (not cleared to 0);
//   no count is lost or double-counted.
//  enable=0: synchroniser/filter keep running and prev-state tracks cur (no backlog on
//   re-enable); steps discarded; period counter held; ps2_mouse holds.
//  reset_n asserted mid-packet: all state returns to reset values immediately; toggle
//   restarts at 0.
//  Y axis sign: positive step = trackball rolled up, matching ps2_mouse convention.
// STRUCTURE
//  trak_pkg: packet bit-position localparams, Gray-code step LUT function, ACC_MAX/ACC_MIN.
//  Sub-module quad_channel (sync + filter + decode -> signed 2-bit step, illegal pulse),
//   instantiated for X and Y; buttons reuse its sync/filter only.
//  Top: accumulators, saturation, period counter, packet register, err_cnt.
// TESTING
//  T1 reset: release reset_n -> ps2_mouse=25'h0000008, err_cnt=0, no toggle for 3 PERIODs idle.
//  T2 X forward 10 Gray steps, each held 8 cycles, within one period -> one packet,
//     [15:8]=8'h0A, [4]=0, [24] toggled once; next period no toggle.
//  T3 Y reverse 300 steps in one period -> [23:16]=8'h00, [5]=1 (-256), [7]=1; next
//     packet after 1 more reverse step shows dY=-1, [7]=0.
//  T4 glitch: 2-cycle pulse on quad_x[0] with FILTER_LEN=4 -> no step, err_cnt unchanged;
//     forced 00->11 transition held 8 cycles -> err_cnt=1, dX unchanged.
//  T5 step arriving on tick cycle -> packet excludes it, following packet dX=+1; sum of all
//     emitted dX equals stimulus steps over 1000 random steps.
//  T6 btn_n[0] low, no motion -> packet with [0]=1, dX=dY=0; enable=0 during motion -> no
//     packets, accumulators 0 after re-enable.

Source files
------------

// File: rtl/trak_pkg.sv
// Shared definitions for the trackball decoder: packet bit positions,
// accumulator limits and the quadrature Gray-code step table.
package trak_pkg;

  localparam int PKT_TOGGLE = 24;
  localparam int PKT_DY_LSB = 16;
  localparam int PKT_DX_LSB = 8;
  localparam int PKT_YOVF   = 7;
  localparam int PKT_XOVF   = 6;
  localparam int PKT_YSIGN  = 5;
  localparam int PKT_XSIGN  = 4;
  localparam int PKT_ONE    = 3;
  localparam int PKT_ZERO   = 2;
  localparam int PKT_RIGHT  = 1;
  localparam int PKT_LEFT   = 0;

  localparam logic [24:0] PKT_RESET = 25'h0000008;

  localparam int ACC_W = 10;
  localparam logic signed [ACC_W-1:0] ACC_MAX = 10'sd255;
  localparam logic signed [ACC_W-1:0] ACC_MIN = -10'sd256;

  typedef struct packed {
    logic                    ovf;
    logic signed [ACC_W-1:0] val;
  } acc_t;

  // Forward order 00->01->11->10->00 is +1; the reverse order is -1.
  function automatic logic signed [1:0] gray_step(input logic [1:0] prev,
                                                  input logic [1:0] cur);
    logic signed [1:0] s;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = 2'sd1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: s = -2'sd1;
      default:                            s = 2'sd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// Per-channel input conditioning: 2-FF synchroniser plus hold filter
// (sync_filter), and a quadrature decoder built on it (quad_channel).
module sync_filter #(
  parameter int         FILTER_LEN = 4,
  parameter logic [1:0] RST_VAL    = 2'b00
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];

  // A bit flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 4'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      filt_q  <= RST_VAL;
      for (int i = 0; i < 2; i++) cnt_q[i] <= 4'd0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dout = filt_q;

endmodule

module quad_channel
  import trak_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int INVERT     = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [1:0]        quad,
  output logic signed [1:0] step,
  output logic              illegal
);

  logic [1:0] filt;
  logic [1:0] prev_q, prev_d;

  sync_filter #(.FILTER_LEN(FILTER_LEN), .RST_VAL(2'b00)) u_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .din     (quad),
    .dout    (filt)
  );

  always_comb begin
    prev_d  = filt;
    illegal = ((prev_q ^ filt) == 2'b11);
    step    = (INVERT != 0) ? -gray_step(prev_q, filt) : gray_step(prev_q, filt);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) prev_q <= 2'b00;
    else          prev_q <= prev_d;
  end

endmodule

// File: rtl/trakball_quad_decoder.sv
// Arcade trackball to ps2_mouse packet bridge: accumulates quadrature steps
// between period ticks and emits a packet only when there is news.
module trakball_quad_decoder
  import trak_pkg::*;
#(
  parameter int PERIOD     = 12000,
  parameter int FILTER_LEN = 4,
  parameter int INVERT_X   = 0,
  parameter int INVERT_Y   = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  quad_x,
  input  logic [1:0]  quad_y,
  input  logic [1:0]  btn_n,
  output logic [24:0] ps2_mouse,
  output logic [7:0]  err_cnt
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic signed [1:0] step_x, step_y, step_x_g, step_y_g;
  logic              ill_x, ill_y;
  logic [1:0]        btn_filt, btn;
  logic              tick, emit;
  acc_t              sum_x, sum_y;

  logic [CNT_W-1:0]        per_cnt_q, per_cnt_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                    ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d;
  logic [1:0]              last_btn_q, last_btn_d;
  logic [24:0]             pkt_q, pkt_d;
  logic [7:0]              err_q, err_d;

  function automatic acc_t sat_add(input logic signed [ACC_W-1:0] acc,
                                   input logic signed [1:0]       stp);
    logic signed [ACC_W:0] sum;
    acc_t                  res;
    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(stp);
    res.ovf = 1'b0;
    res.val = sum[ACC_W-1:0];
    if (sum > (ACC_W+1)'(ACC_MAX)) begin
      res.ovf = 1'b1;
      res.val = ACC_MAX;
    end else if (sum < (ACC_W+1)'(ACC_MIN)) begin
      res.ovf = 1'b1;
      res.val = ACC_MIN;
    end
    return res;
  endfunction

  function automatic logic [7:0] err_sat(input logic [7:0] cnt, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  quad_channel #(.FILTER_LEN(FILTER_LEN), .INVERT(INVERT_X)) u_x (
    .clk_sys (clk_sys), .reset_n (reset_n), .quad (quad_x),
    .step    (step_x),  .illegal (ill_x)
  );

  quad_channel #(.FILTER_LEN(FILTER_LEN), .INVERT(INVERT_Y)) u_y (
    .clk_sys (clk_sys), .reset_n (reset_n), .quad (quad_y),
    .step    (step_y),  .illegal (ill_y)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN), .RST_VAL(2'b11)) u_btn (
    .clk_sys (clk_sys), .reset_n (reset_n), .din (btn_n), .dout (btn_filt)
  );

  always_comb begin
    btn       = ~btn_filt;
    step_x_g  = enable ? step_x : 2'sd0;
    step_y_g  = enable ? step_y : 2'sd0;
    sum_x     = sat_add(acc_x_q, step_x_g);
    sum_y     = sat_add(acc_y_q, step_y_g);
    tick      = enable && (per_cnt_q == CNT_W'(PERIOD - 1));
    emit      = tick && ((acc_x_q != '0) || (acc_y_q != '0) || (btn != last_btn_q));

    per_cnt_d  = per_cnt_q;
    acc_x_d    = sum_x.val;
    acc_y_d    = sum_y.val;
    ovf_x_d    = ovf_x_q | sum_x.ovf;
    ovf_y_d    = ovf_y_q | sum_y.ovf;
    last_btn_d = last_btn_q;
    pkt_d      = pkt_q;
    err_d      = err_sat(err_q, {1'b0, ill_x & enable} + {1'b0, ill_y & enable});

    if (enable) per_cnt_d = tick ? '0 : per_cnt_q + CNT_W'(1);

    // The packet reports the pre-tick totals; a step landing on the same
    // cycle seeds the next accumulation instead of being dropped.
    if (emit) begin
      pkt_d[PKT_TOGGLE]          = ~pkt_q[PKT_TOGGLE];
      pkt_d[PKT_DY_LSB +: 8]     = acc_y_q[7:0];
      pkt_d[PKT_DX_LSB +: 8]     = acc_x_q[7:0];
      pkt_d[PKT_YOVF]            = ovf_y_q;
      pkt_d[PKT_XOVF]            = ovf_x_q;
      pkt_d[PKT_YSIGN]           = acc_y_q[8];
      pkt_d[PKT_XSIGN]           = acc_x_q[8];
      pkt_d[PKT_ONE]             = 1'b1;
      pkt_d[PKT_ZERO]            = 1'b0;
      pkt_d[PKT_RIGHT]           = btn[1];
      pkt_d[PKT_LEFT]            = btn[0];
      acc_x_d                    = ACC_W'(step_x_g);
      acc_y_d                    = ACC_W'(step_y_g);
      ovf_x_d                    = 1'b0;
      ovf_y_d                    = 1'b0;
      last_btn_d                 = btn;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt_q  <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      ovf_x_q    <= 1'b0;
      ovf_y_q    <= 1'b0;
      last_btn_q <= 2'b00;
      pkt_q      <= PKT_RESET;
      err_q      <= 8'd0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      ovf_x_q    <= ovf_x_d;
      ovf_y_q    <= ovf_y_d;
      last_btn_q <= last_btn_d;
      pkt_q      <= pkt_d;
      err_q      <= err_d;
    end
  end

  assign ps2_mouse = pkt_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_trakball_quad_decoder.sv
// Bench for trakball_quad_decoder: an arithmetic reference model predicts
// packets into a queue; a monitor compares every packet change the DUT shows.
module tb_trakball_quad_decoder;

  localparam int PERIOD = 2000;
  localparam int FL     = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b1;
  logic [1:0]  quad_x  = 2'b00;
  logic [1:0]  quad_y  = 2'b00;
  logic [1:0]  btn_n   = 2'b11;
  logic [24:0] ps2_mouse;
  logic [7:0]  err_cnt;

  trakball_quad_decoder #(.PERIOD(PERIOD), .FILTER_LEN(FL), .INVERT_X(0), .INVERT_Y(0)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .quad_x    (quad_x),
    .quad_y    (quad_y),
    .btn_n     (btn_n),
    .ps2_mouse (ps2_mouse),
    .err_cnt   (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q [$];

  // Reference model state: pin history, filtered values, totals.
  logic [5:0] hist [FL+2];
  logic [5:0] mfilt;
  logic [3:0] mprev;
  int         mcnt, accx, accy, merr;
  logic       ovfx, ovfy, mtog;
  logic [1:0] mlast_btn;

  function automatic int gpos(input logic [1:0] g);
    case (g)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // Position difference mod 4: 1 forward, 3 backward, 2 impossible jump.
  function automatic int qdiff(input logic [1:0] p, input logic [1:0] c);
    return (gpos(c) - gpos(p) + 4) % 4;
  endfunction

  task automatic sat_acc(inout int acc, inout logic ovf, input int d);
    acc = acc + d;
    if (acc > 255)  begin acc = 255;  ovf = 1'b1; end
    if (acc < -256) begin acc = -256; ovf = 1'b1; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < FL + 2; k++) hist[k] = 6'b110000;
    mfilt = 6'b110000; mprev = 4'b0000;
    mcnt = 0; accx = 0; accy = 0; merr = 0;
    ovfx = 1'b0; ovfy = 1'b0; mtog = 1'b0; mlast_btn = 2'b00;
  endtask

  always @(posedge clk_sys) begin : model
    int cx, cy, dx, dy, nill;
    logic [1:0] btn;
    logic [24:0] p;
    bit all_diff;
    if (!reset_n) model_reset();
    else begin
      cx = qdiff(mprev[1:0], mfilt[1:0]);
      cy = qdiff(mprev[3:2], mfilt[3:2]);
      dx = (cx == 1) ? 1 : (cx == 3) ? -1 : 0;
      dy = (cy == 1) ? 1 : (cy == 3) ? -1 : 0;
      nill = (cx == 2 ? 1 : 0) + (cy == 2 ? 1 : 0);
      btn = ~mfilt[5:4];
      if (!enable) begin dx = 0; dy = 0; nill = 0; end
      merr = (merr + nill > 255) ? 255 : merr + nill;
      if (enable && mcnt == PERIOD - 1) begin
        mcnt = 0;
        if (accx != 0 || accy != 0 || btn != mlast_btn) begin
          mtog = ~mtog;
          p = {mtog, accy[7:0], accx[7:0], ovfy, ovfx, accy[8], accx[8], 1'b1, 1'b0, btn};
          exp_q.push_back(p);
          accx = dx; accy = dy; ovfx = 1'b0; ovfy = 1'b0; mlast_btn = btn;
        end else begin
          sat_acc(accx, ovfx, dx);
          sat_acc(accy, ovfy, dy);
        end
      end else begin
        if (enable) mcnt++;
        sat_acc(accx, ovfx, dx);
        sat_acc(accy, ovfy, dy);
      end
      mprev = mfilt[3:0];
      for (int k = FL + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {btn_n, quad_y, quad_x};
      for (int b = 0; b < 6; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k < FL + 2; k++) if (hist[k][b] == mfilt[b]) all_diff = 1'b0;
        if (all_diff) mfilt[b] = ~mfilt[b];
      end
    end
  end

  // Monitor: any change of ps2_mouse is a packet and must match the queue head.
  logic [24:0] last_seen = 25'h0000008;
  logic [24:0] last_pkt  = 25'h0000008;
  logic [7:0]  last_err  = 8'd0;
  int          last_merr = 0;
  int          dut_pkts  = 0;
  int          sum_dx    = 0;

  always @(posedge clk_sys) begin : monitor
    logic [24:0] e;
    logic signed [8:0] v;
    #1;
    if (!reset_n) begin
      last_seen = 25'h0000008; last_err = 8'd0; last_merr = 0;
    end else begin
      if (ps2_mouse !== last_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pkt: got %h, expected no packet", ps2_mouse);
        end else begin
          e = exp_q.pop_front();
          if (ps2_mouse !== e) begin
            errors++;
            $display("FAIL pkt: got %h, expected %h", ps2_mouse, e);
          end
        end
        last_seen = ps2_mouse; last_pkt = ps2_mouse; dut_pkts++;
        v = {ps2_mouse[4], ps2_mouse[15:8]};
        sum_dx += v;
      end
      if (err_cnt !== last_err || merr != last_merr) begin
        checks++;
        if (err_cnt !== merr[7:0]) begin
          errors++;
          $display("FAIL err_cnt: got %0d, expected %0d", err_cnt, merr);
        end
        last_err = err_cnt; last_merr = merr;
      end
    end
  end

  logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int px = 0, py = 0, stim_dx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step_x(input int dir, input int hold);
    px = (px + dir + 4) % 4; quad_x = GRAY[px]; stim_dx += dir;
    repeat (hold) @(negedge clk_sys);
  endtask

  task automatic step_y(input int dir, input int hold);
    py = (py + dir + 4) % 4; quad_y = GRAY[py];
    repeat (hold) @(negedge clk_sys);
  endtask

  task automatic wait_cnt(input int c);
    int i;
    @(negedge clk_sys);
    for (i = 0; i < 3 * PERIOD && mcnt != c; i++) @(negedge clk_sys);
    if (mcnt != c) begin
      checks++; errors++;
      $display("FAIL wait_cnt_timeout: got count %0d, expected %0d", mcnt, c);
    end
  endtask

  initial begin
    int s0, pk;
    repeat (4) @(negedge clk_sys);
    reset_n = 1'b1;
    check("reset_pkt", 32'(ps2_mouse), 32'h8);
    check("reset_err", 32'(err_cnt), 0);

    // T1: idle for three periods
    repeat (3 * PERIOD + 10) @(negedge clk_sys);
    check("t1_no_pkt", dut_pkts, 0);
    check("t1_pkt_idle", 32'(ps2_mouse), 32'h8);

    // T2: ten forward X steps inside one period
    wait_cnt(10);
    for (int i = 0; i < 10; i++) step_x(1, 8);
    wait_cnt(5);
    check("t2_pkts", dut_pkts, 1);
    check("t2_dx", 32'(last_pkt[15:8]), 32'h0A);
    check("t2_xsign", 32'(last_pkt[4]), 0);
    check("t2_toggle", 32'(last_pkt[24]), 1);
    wait_cnt(5);
    check("t2_no_retoggle", dut_pkts, 1);

    // T3: 300 reverse Y steps saturate, then one more
    wait_cnt(2);
    for (int i = 0; i < 300; i++) step_y(-1, 5);
    wait_cnt(10);
    check("t3_pkts", dut_pkts, 2);
    check("t3_dy", 32'(last_pkt[23:16]), 0);
    check("t3_ysign", 32'(last_pkt[5]), 1);
    check("t3_yovf", 32'(last_pkt[7]), 1);
    step_y(-1, 5);
    wait_cnt(5);
    check("t3b_dy", 32'(last_pkt[23:16]), 32'hFF);
    check("t3b_ysign", 32'(last_pkt[5]), 1);
    check("t3b_yovf", 32'(last_pkt[7]), 0);

    // T4: bring pins home, reset mid-packet, then glitch and illegal jump
    step_x(1, 8); step_x(1, 8); step_y(1, 8);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("t4_reset_pkt", 32'(ps2_mouse), 32'h8);
    check("t4_reset_err", 32'(err_cnt), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    quad_x[0] = 1'b1;
    repeat (2) @(negedge clk_sys);
    quad_x[0] = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("t4_glitch_err", 32'(err_cnt), 0);
    px = 2; quad_x = GRAY[px];
    repeat (18) @(negedge clk_sys);
    check("t4_illegal_err", 32'(err_cnt), 1);
    step_x(1, 8); step_x(1, 8);
    wait_cnt(5);
    check("t4_toggle_restart", 32'(last_pkt[24]), 1);
    check("t4_dx", 32'(last_pkt[15:8]), 32'h02);

    // T5: step landing on the tick, then random conservation run
    s0 = sum_dx; stim_dx = 0; pk = dut_pkts;
    wait_cnt(100);
    step_x(1, 4);
    wait_cnt(PERIOD - 3 - FL);
    step_x(1, 8);
    wait_cnt(5);
    check("t5_tick_pkts", dut_pkts, pk + 1);
    check("t5_tick_dx", 32'(last_pkt[15:8]), 1);
    wait_cnt(5);
    check("t5_next_pkts", dut_pkts, pk + 2);
    check("t5_next_dx", 32'(last_pkt[15:8]), 1);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) step_y(($urandom_range(0, 1) != 0) ? 1 : -1, 0);
      step_x(($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(4, 10));
    end
    wait_cnt(5);
    wait_cnt(5);
    check("t5_sum_dx", 32'(sum_dx - s0), 32'(stim_dx));

    // T6: button packet, release packet, motion while disabled
    btn_n[0] = 1'b0;
    wait_cnt(5);
    check("t6_left", 32'(last_pkt[0]), 1);
    check("t6_dx0", 32'(last_pkt[15:8]), 0);
    check("t6_dy0", 32'(last_pkt[23:16]), 0);
    btn_n[0] = 1'b1;
    wait_cnt(5);
    check("t6_release", 32'(last_pkt[0]), 0);
    pk = dut_pkts;
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step_x(($urandom_range(0, 1) != 0) ? 1 : -1, 3);
      step_y(($urandom_range(0, 1) != 0) ? 1 : -1, 3);
    end
    repeat (2 * PERIOD) @(negedge clk_sys);
    check("t6_disabled_pkts", dut_pkts, pk);
    enable = 1'b1;
    repeat (2 * PERIOD + 10) @(negedge clk_sys);
    check("t6_reenable_pkts", dut_pkts, pk);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
